hash_unit: RTL and testbench



---
 rtl/hash_unit.sv | 92 +++++++++
 tb/tb_hash_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hash_unit.sv
// hash_unit: four-stage k-mer hash with range reduction to a table index.
// The key, the 2-bit tag and the per-item seed/table_size travel with each item.
module hash_unit #(
  parameter int          KEY_W = 200,
  parameter logic [31:0] PRIME = 32'h01000193,
  parameter logic [31:0] MIX_C = 32'h85EBCA6B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [KEY_W-1:0] key,
  input  logic [31:0]      seed,
  input  logic [31:0]      table_size,
  input  logic [1:0]       ctr_in,
  output logic [KEY_W-1:0] key_out,
  output logic [31:0]      table_index,
  output logic [1:0]       ctr_out
);

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [1:0]       ctr;
    logic [31:0]      tsize;
    logic [31:0]      h;
  } stage_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [1:0]       ctr;
    logic [31:0]      index;
  } out_t;

  stage_t s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
  out_t   s4_d, s4_q;

  function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] w);
    return (h ^ w) * PRIME;
  endfunction

  // The top word carries only the last 8 key bits, zero-extended.
  function automatic logic [31:0] key_word(input logic [KEY_W-1:0] k, input int i);
    logic [223:0] padded;
    padded = 224'(k);
    return padded[32*i +: 32];
  endfunction

  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first (no latches); the registers below use non-blocking '<=' only.
  always_comb begin
    s1_d       = '0;
    s1_d.key   = key;
    s1_d.ctr   = ctr_in;
    s1_d.tsize = table_size;
    s1_d.h     = seed;
    for (int i = 0; i < 3; i++) s1_d.h = mix(s1_d.h, key_word(key, i));

    s2_d = s1_q;
    for (int i = 3; i < 7; i++) s2_d.h = mix(s2_d.h, key_word(s1_q.key, i));

    s3_d   = s2_q;
    s3_d.h = s2_q.h ^ (s2_q.h >> 16);
    s3_d.h = s3_d.h * MIX_C;
    s3_d.h = s3_d.h ^ (s3_d.h >> 13);

    // High half of the 64-bit product is the index; always < tsize, 0 when tsize=0.
    s4_d       = '0;
    s4_d.key   = s3_q.key;
    s4_d.ctr   = s3_q.ctr;
    s4_d.index = 32'((64'(s3_q.h) * 64'(s3_q.tsize)) >> 32);
  end

  // NOTE: every pipeline register is cleared on reset so in-flight items are
  // discarded and outputs read as empty (ctr_out=0) straight away.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else if (!stall) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
    end
  end

  assign key_out     = s4_q.key;
  assign table_index = s4_q.index;
  assign ctr_out     = s4_q.ctr;

endmodule

// File: tb/tb_hash_unit.sv
// tb_hash_unit: randomized and directed checks of hash_unit against a
// whole-item reference hash and a delay line of accepted items.
module tb_hash_unit;

  localparam logic [31:0] PRIME = 32'h01000193;
  localparam logic [31:0] MIX_C = 32'h85EBCA6B;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic [199:0] key;
  logic [31:0]  seed;
  logic [31:0]  table_size;
  logic [1:0]   ctr_in;
  logic [199:0] key_out;
  logic [31:0]  table_index;
  logic [1:0]   ctr_out;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [199:0] key;
    logic [31:0]  seed;
    logic [31:0]  ts;
    logic [1:0]   ctr;
  } item_t;

  item_t pipe[$];

  hash_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .key        (key),
    .seed       (seed),
    .table_size (table_size),
    .ctr_in     (ctr_in),
    .key_out    (key_out),
    .table_index(table_index),
    .ctr_out    (ctr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_index(input logic [199:0] k, input logic [31:0] s,
                                            input logic [31:0] ts);
    logic [223:0] kp;
    logic [31:0]  h;
    logic [63:0]  p;
    kp = {24'b0, k};
    h  = s;
    for (int i = 0; i < 7; i++) h = (h ^ kp[32*i +: 32]) * PRIME;
    h ^= h >> 16;
    h  = h * MIX_C;
    h ^= h >> 13;
    p  = {32'b0, h} * {32'b0, ts};
    return p[63:32];
  endfunction

  function automatic item_t empty_item();
    item_t it;
    it.key = '0; it.seed = '0; it.ts = '0; it.ctr = '0;
    return it;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < 4; i++) pipe.push_back(empty_item());
  endtask

  // One clock edge: update the delay-line model, then compare all outputs.
  task automatic step();
    item_t it, oldest;
    @(posedge clk);
    if (rst) model_reset();
    else if (!stall) begin
      it.key = key; it.seed = seed; it.ts = table_size; it.ctr = ctr_in;
      pipe.push_front(it);
      void'(pipe.pop_back());
    end
    #1;
    oldest = pipe[3];
    check("key_out", key_out, oldest.key);
    check("ctr_out", 200'(ctr_out), 200'(oldest.ctr));
    check("table_index", 200'(table_index), 200'(ref_index(oldest.key, oldest.seed, oldest.ts)));
    if (oldest.ts > 1) check("index_range", 200'(table_index < oldest.ts), 200'(1));
    else check("index_small_ts", 200'(table_index), 200'(0));
  endtask

  task automatic drive(input logic [199:0] k, input logic [31:0] s, input logic [31:0] ts,
                       input logic [1:0] c);
    key = k; seed = s; table_size = ts; ctr_in = c;
  endtask

  function automatic logic [199:0] rand_key();
    logic [223:0] tmp;
    tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return tmp[199:0];
  endfunction

  function automatic logic [31:0] rand_ts();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  localparam logic [199:0] LAT_KEY = 200'h14E21F5976ED08A2D4B7A959595A58754E99D50D50D50D50D5;

  initial begin
    logic [199:0] frz_key;
    logic [31:0]  frz_idx;
    logic [1:0]   frz_ctr;
    model_reset();
    stall = 1'b0;

    // Reset with nonzero inputs
    rst = 1'b1;
    drive(rand_key(), 32'hDEADBEEF, 32'h1234, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_key", key_out, '0);
      check("reset_idx", 200'(table_index), '0);
      check("reset_ctr", 200'(ctr_out), '0);
    end
    rst = 1'b0;

    // Zero key, single tagged item followed by bubbles
    drive('0, '0, 32'h4C62, 2'd3);
    step();
    drive('0, '0, 32'h4C62, 2'd0);
    for (int i = 2; i <= 6; i++) begin
      step();
      if (i == 4) begin
        check("zero_ctr", 200'(ctr_out), 200'(3));
        check("zero_idx", 200'(table_index), '0);
        check("zero_key", key_out, '0);
      end else if (i > 4) begin
        check("zero_after_ctr", 200'(ctr_out), '0);
      end else begin
        check("zero_before_ctr", 200'(ctr_out), '0);
      end
    end

    // Latency / alignment with the reference key
    drive(LAT_KEY, '0, 32'h4C62, 2'd3);
    step();
    drive('0, '0, '0, 2'd0);
    for (int i = 2; i <= 4; i++) begin
      step();
      if (i < 4) check("lat_early_ctr", 200'(ctr_out), '0);
    end
    check("lat_ctr", 200'(ctr_out), 200'(3));
    check("lat_key", key_out, LAT_KEY);
    check("lat_idx", 200'(table_index), 200'(ref_index(LAT_KEY, '0, 32'h4C62)));
    check("lat_range", 200'(table_index < 32'h4C62), 200'(1));

    // Stream, then a 5-cycle stall with frozen outputs, then resume
    for (int i = 0; i < 8; i++) begin
      drive(rand_key(), $urandom(), rand_ts(), 2'($urandom_range(1, 3)));
      step();
    end
    frz_key = key_out; frz_idx = table_index; frz_ctr = ctr_out;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(rand_key(), $urandom(), rand_ts(), 2'd3);
      step();
      check("stall_key", key_out, frz_key);
      check("stall_idx", 200'(table_index), 200'(frz_idx));
      check("stall_ctr", 200'(ctr_out), 200'(frz_ctr));
    end
    stall = 1'b0;

    // Random streaming: per-item seed/table_size, random stalls and bubbles
    for (int i = 0; i < 1000; i++) begin
      stall = ($urandom_range(0, 9) == 0);
      drive(rand_key(), $urandom(), rand_ts(), 2'($urandom_range(0, 3)));
      step();
    end
    stall = 1'b0;

    // Reset mid-stream discards in-flight items
    drive(rand_key(), $urandom(), rand_ts(), 2'd2);
    step();
    rst = 1'b1;
    step();
    check("midrst_ctr", 200'(ctr_out), '0);
    rst = 1'b0;
    drive('0, '0, '0, 2'd0);
    for (int i = 0; i < 5; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
